// File: rtl/crc_accumulator.sv
// Streaming CRC engine with a runtime-configurable width, polynomial, reflection and final XOR.
// It consumes one FRAME_SIZE-bit word per accepted beat and emits a one-cycle crc_valid per completed message.
module crc_accumulator #(
  parameter int CRC_SIZE   = 32,
  parameter int FRAME_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CRC_SIZE-1:0]   crc_init,
  input  logic [CRC_SIZE-1:0]   crc_poly,
  input  logic [CRC_SIZE-1:0]   crc_poly_size,
  input  logic                  rev_in,
  input  logic                  rev_out,
  input  logic [CRC_SIZE-1:0]   xor_out,
  input  logic [FRAME_SIZE-1:0] data_in,
  input  logic                  data_valid,
  input  logic                  data_last,
  output logic                  data_ready,
  output logic                  busy,
  output logic [CRC_SIZE-1:0]   crc_out,
  output logic                  crc_valid
);

  typedef enum logic [1:0] {IDLE, RUN, FINAL} state_t;

  state_t                state, state_next;
  logic [CRC_SIZE-1:0]   crc_reg;
  logic [CRC_SIZE-1:0]   poly_q, mask_q, xor_q;
  logic                  rev_in_q, rev_out_q;
  logic [FRAME_SIZE-1:0] frame;
  logic                  accept;

  function automatic logic [FRAME_SIZE-1:0] reverse_frame(input logic [FRAME_SIZE-1:0] d);
    logic [FRAME_SIZE-1:0] r;
    for (int i = 0; i < FRAME_SIZE; i++) r[i] = d[FRAME_SIZE-1-i];
    return r;
  endfunction

  // The top bit of the active width is the single mask bit whose upper neighbour is clear.
  function automatic logic [CRC_SIZE-1:0] crc_step(input logic [CRC_SIZE-1:0]   c_in,
                                                   input logic [FRAME_SIZE-1:0] d,
                                                   input logic [CRC_SIZE-1:0]   poly,
                                                   input logic [CRC_SIZE-1:0]   mask);
    logic [CRC_SIZE-1:0] c;
    logic [CRC_SIZE-1:0] top;
    logic                fb;
    c   = c_in;
    top = mask & ~(mask >> 1);
    for (int i = FRAME_SIZE - 1; i >= 0; i--) begin
      fb = d[i] ^ (|(c & top));
      c  = ((c << 1) ^ (fb ? poly : '0)) & mask;
    end
    return c;
  endfunction

  // Full-width reversal followed by a right shift leaves the reflection of bits [w-1:0].
  function automatic logic [CRC_SIZE-1:0] reflect(input logic [CRC_SIZE-1:0] v,
                                                  input logic [CRC_SIZE-1:0] mask);
    logic [CRC_SIZE-1:0] r;
    int                  w;
    w = 0;
    for (int i = 0; i < CRC_SIZE; i++) begin
      r[i] = v[CRC_SIZE-1-i];
      if (mask[i]) w = w + 1;
    end
    return r >> (CRC_SIZE - w);
  endfunction

  assign data_ready = (state == RUN) && !start;
  assign busy       = (state == RUN) || (state == FINAL);
  assign accept     = data_valid && data_ready;
  assign frame      = rev_in_q ? reverse_frame(data_in) : data_in;

  always_comb begin
    state_next = state;
    if (start) begin
      state_next = RUN;
    end else begin
      case (state)
        RUN:     if (accept && data_last) state_next = FINAL;
        FINAL:   state_next = IDLE;
        default: state_next = state;
      endcase
    end
  end

  // A start in FINAL takes the start branch, so an aborted message never raises crc_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      crc_reg   <= '0;
      crc_out   <= '0;
      crc_valid <= 1'b0;
      poly_q    <= '0;
      mask_q    <= '0;
      xor_q     <= '0;
      rev_in_q  <= 1'b0;
      rev_out_q <= 1'b0;
    end else begin
      state     <= state_next;
      crc_valid <= 1'b0;
      if (start) begin
        poly_q    <= crc_poly;
        mask_q    <= crc_poly_size;
        xor_q     <= xor_out;
        rev_in_q  <= rev_in;
        rev_out_q <= rev_out;
        crc_reg   <= crc_init & crc_poly_size;
      end else if (accept) begin
        crc_reg <= crc_step(crc_reg, frame, poly_q, mask_q);
      end else if (state == FINAL) begin
        crc_out   <= ((rev_out_q ? reflect(crc_reg, mask_q) : crc_reg) ^ xor_q) & mask_q;
        crc_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_crc_accumulator.sv
// Scoreboard bench for crc_accumulator: stimulus queues the hand-computed CRCs of well-known
// check strings, and an independent monitor compares them whenever crc_valid pulses.
module tb_crc_accumulator;

  logic        clk = 1'b0;
  logic        rst, start, rev_in, rev_out, data_valid, data_last;
  logic [31:0] crc_init, crc_poly, crc_poly_size, xor_out;
  logic [7:0]  data_in;
  logic        data_ready, busy, crc_valid;
  logic [31:0] crc_out;

  int          tests  = 0;
  int          failed = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  crc_accumulator #(.CRC_SIZE(32), .FRAME_SIZE(8)) dut (
    .clk(clk), .rst(rst), .start(start), .crc_init(crc_init), .crc_poly(crc_poly),
    .crc_poly_size(crc_poly_size), .rev_in(rev_in), .rev_out(rev_out), .xor_out(xor_out),
    .data_in(data_in), .data_valid(data_valid), .data_last(data_last),
    .data_ready(data_ready), .busy(busy), .crc_out(crc_out), .crc_valid(crc_valid)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every crc_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (crc_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("[TB] FAIL unexpected_crc_valid: got crc_out %h, expected no result", crc_out);
      end else begin
        check_output("crc_out", crc_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Tasks enter and leave just after a rising edge.
  task automatic start_crc(input logic [31:0] init, input logic [31:0] poly, input logic [31:0] mask,
                           input logic ri, input logic ro, input logic [31:0] xo);
    crc_init = init; crc_poly = poly; crc_poly_size = mask;
    rev_in = ri; rev_out = ro; xor_out = xo;
    start = 1'b1;
    @(negedge clk);
    check_output("ready_in_start", 32'(data_ready), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    crc_init = $urandom; crc_poly = $urandom; crc_poly_size = $urandom;
    rev_in = ~ri; rev_out = ~ro; xor_out = $urandom;
  endtask

  task automatic apply_stimulus(input logic [7:0] d, input logic last);
    int n = 0;
    data_in = d; data_valid = 1'b1; data_last = last;
    @(negedge clk);
    while (!data_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!data_ready) begin
      tests++;
      failed++;
      $display("[TB] FAIL beat_timeout: got data_ready 0, expected 1");
    end
    @(posedge clk); #1;
    data_valid = 1'b0; data_last = 1'b0;
  endtask

  task automatic idle_gap(input int n);
    data_valid = 1'b0; data_last = 1'b1; data_in = 8'($urandom);
    repeat (n) begin
      @(posedge clk); #1;
    end
    data_last = 1'b0;
  endtask

  task automatic send_check_string();
    for (int i = 0; i < 9; i++) apply_stimulus(8'(8'h31 + i), i == 8);
  endtask

  task automatic wait_result();
    int n = 0;
    @(negedge clk);
    while (crc_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (crc_valid !== 1'b1) begin
      tests++;
      failed++;
      $display("[TB] FAIL result_timeout: got crc_valid 0, expected 1");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; rev_in = 1'b1; rev_out = 1'b1;
    data_valid = 1'b1; data_last = 1'b1; data_in = 8'hA5;
    crc_init = '1; crc_poly = '1; crc_poly_size = '1; xor_out = '1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0; data_valid = 1'b0; data_last = 1'b0;
    @(negedge clk);
    check_output("reset_crc_out", crc_out, 32'h0);
    check_output("reset_crc_valid", 32'(crc_valid), 32'd0);
    check_output("reset_data_ready", 32'(data_ready), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // CRC-8 with latency and busy checks around the last beat.
    start_crc(32'h0, 32'h07, 32'hFF, 1'b0, 1'b0, 32'h0);
    exp_q.push_back(32'h0000_00F4);
    send_check_string();
    @(negedge clk);
    check_output("final_valid_low", 32'(crc_valid), 32'd0);
    check_output("final_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check_output("latency_valid", 32'(crc_valid), 32'd1);
    check_output("done_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // CRC-16/CCITT-FALSE with idle gaps carrying a stray data_last.
    start_crc(32'hFFFF, 32'h1021, 32'hFFFF, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_output("hold_after_start", crc_out, 32'h0000_00F4);
    @(posedge clk); #1;
    exp_q.push_back(32'h0000_29B1);
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(8'(8'h31 + i), i == 8);
      if (i % 3 == 1) idle_gap(2);
    end
    wait_result();

    // Reflected CRC-32.
    start_crc(32'hFFFF_FFFF, 32'h04C1_1DB7, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hFFFF_FFFF);
    exp_q.push_back(32'hCBF4_3926);
    send_check_string();
    wait_result();

    // Abort a CRC-32 after four bytes with a fresh CRC-8 start.
    start_crc(32'hFFFF_FFFF, 32'h04C1_1DB7, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) apply_stimulus(8'(8'h31 + i), 1'b0);
    start_crc(32'h0, 32'h07, 32'hFF, 1'b0, 1'b0, 32'h0);
    exp_q.push_back(32'h0000_00F4);
    send_check_string();
    wait_result();
    idle_gap(4);

    // Reset mid-message, then configuration churn and data without a start.
    start_crc(32'hFFFF_FFFF, 32'h04C1_1DB7, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) apply_stimulus(8'(8'h31 + i), 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    data_valid = 1'b1; data_last = 1'b1; data_in = 8'h31;
    for (int i = 0; i < 6; i++) begin
      crc_poly = $urandom; crc_poly_size = $urandom; crc_init = $urandom; xor_out = $urandom;
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_output("post_reset_ready", 32'(data_ready), 32'd0);
    check_output("post_reset_crc_out", crc_out, 32'h0);
    check_output("post_reset_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    data_valid = 1'b0; data_last = 1'b0;

    // Single-beat message.
    start_crc(32'h0, 32'h07, 32'hFF, 1'b0, 1'b0, 32'h0);
    exp_q.push_back(32'h0000_0007);
    apply_stimulus(8'h01, 1'b1);
    @(negedge clk);
    check_output("single_final_busy", 32'(busy), 32'd1);
    check_output("single_final_valid", 32'(crc_valid), 32'd0);
    @(negedge clk);
    check_output("single_valid", 32'(crc_valid), 32'd1);
    check_output("single_busy_fall", 32'(busy), 32'd0);
    @(posedge clk); #1;
    idle_gap(3);

    check_output("pending_results", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/crc_accumulator.md
CRC_ACCUMULATOR -- requirements
Module: crc_accumulator

Interface
REQ-001 The block SHALL have parameter CRC_SIZE, default 32: maximum CRC width in bits.
REQ-002 The block SHALL have parameter FRAME_SIZE, default 8: data word width in bits consumed per accepted beat.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports as listed below.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  begin new CRC computation; latches configuration inputs.
REQ-007 crc_init  input  CRC_SIZE  initial CRC value, LSB-aligned to active width.
REQ-008 crc_poly  input  CRC_SIZE  generator polynomial without implicit top term, LSB-aligned.
REQ-009 crc_poly_size  input  CRC_SIZE  active-width mask; bits [w-1:0] set for CRC width w, 1 <= w <= CRC_SIZE.
REQ-010 rev_in  input  1  reverse bit order of each data word before processing.
REQ-011 rev_out  input  1  reverse bit order of the final CRC within the active width.
REQ-012 xor_out  input  CRC_SIZE  final XOR value, LSB-aligned.
REQ-013 data_in  input  FRAME_SIZE  data word; processed MSB-first after optional reversal.
REQ-014 data_valid  input  1  data_in valid this cycle.
REQ-015 data_last  input  1  qualifies data_in as final word of the message.
REQ-016 data_ready  output  1  block accepts a word this cycle.
REQ-017 busy  output  1  high in RUN and FINAL states.
REQ-018 crc_out  output  CRC_SIZE  final CRC; bits at and above active width are 0.
REQ-019 crc_valid  output  1  one-cycle pulse when crc_out is updated with a new result.

Function
REQ-020 The FSM SHALL have exactly the states IDLE, RUN, and FINAL.
REQ-021 In any state, start SHALL latch crc_init, crc_poly, crc_poly_size, rev_in, rev_out, and xor_out, and SHALL load crc_reg with crc_init masked by crc_poly_size.
REQ-022 A start in any state SHALL move the FSM to RUN on the next cycle; this aborts any computation in progress, and no crc_valid SHALL be produced for the aborted message.
REQ-023 data_ready SHALL equal (state == RUN) AND NOT start, combinationally.
REQ-024 A beat SHALL be accepted only when data_valid and data_ready are both high.
REQ-025 A beat accepted at edge t SHALL update crc_reg at edge t with a FRAME_SIZE-bit MSB-first CRC step over the latched active width and polynomial, using the latched configuration only.
REQ-026 In the CRC step, per bit: fb = bit XOR crc_reg[w-1]; then crc_reg = ((crc_reg << 1) XOR (fb ? poly : 0)) AND mask.
REQ-027 When data_valid is low in RUN, crc_reg SHALL hold.
REQ-028 data_last SHALL be ignored on non-accepted cycles.
REQ-029 Acceptance of a beat with data_last high SHALL move the FSM from RUN to FINAL.
REQ-030 In FINAL, crc_out SHALL be loaded with (crc_reg, reversed over bits [w-1:0] if latched rev_out) XOR xor_out, AND mask.
REQ-031 In FINAL, crc_valid SHALL pulse for one cycle, and the FSM SHALL return to IDLE.
REQ-032 Latency: last beat accepted at edge t SHALL produce crc_valid=1 and the new crc_out in the cycle after edge t+1.
REQ-033 crc_out SHALL hold its value until the next FINAL or reset; a new start SHALL NOT clear it.
REQ-034 Changes to configuration inputs while not in start SHALL have no effect.
REQ-035 Single-beat messages (start, then one beat with data_last) SHALL be legal.
REQ-036 Zero-beat messages SHALL be unsupported: the FSM remains in RUN until a last beat or start.
REQ-037 start and rst both high SHALL result in reset behaviour.

Reset
REQ-038 On rst, the FSM SHALL enter IDLE, with crc_reg=0, crc_out=0, crc_valid=0, data_ready=0, busy=0, and all latched configuration cleared to 0.
REQ-039 Reset mid-message SHALL discard all progress and produce no crc_valid.

Verification
REQ-040 CRC-8: mask 0xFF, poly 0x07, init 0, no reversal, xor 0, bytes "123456789" -> crc_out=0x00000F4, crc_valid one pulse 2 cycles after last.
REQ-041 CRC-16/CCITT-FALSE: mask 0xFFFF, poly 0x1021, init 0xFFFF, xor 0, "123456789" with data_valid gaps -> crc_out=0x000029B1, gaps do not alter result.
REQ-042 CRC-32: mask 0xFFFFFFFF, poly 0x04C11DB7, init 0xFFFFFFFF, rev_in=rev_out=1, xor 0xFFFFFFFF, "123456789" -> crc_out=0xCBF43926.
REQ-043 Abort: start mid-CRC-32 message after 4 bytes, then full CRC-8 "123456789" -> single crc_valid, crc_out=0x000000F4; data_ready=0 in the start cycle.
REQ-044 Reset mid-message, then config changes without start plus data_valid -> no crc_valid, data_ready=0, crc_out=0.
REQ-045 Single-beat: CRC-8, poly 0x07, init 0, byte 0x01 with data_last -> crc_out=0x00000007, busy falls with crc_valid.
